// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/write-back
// sequencing with a memory-ready stall, optional wait timeout and a retired-instruction counter.
module multicycle_control #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             branch_ne,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             ExtOp,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             mem_error,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam int WCNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    state_t            state_q, state_d, dec_state;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              mem_wait_state;
    logic              timeout;

    always_comb begin
        // Reset shows FETCH selects; strobes are masked further down.
        dec_state      = rst ? S_FETCH : state_q;
        mem_wait_state = (dec_state == S_FETCH) || (dec_state == S_MEM_READ) ||
                         (dec_state == S_MEM_WRITE);
        timeout        = (WAIT_LIMIT != 0) && mem_wait_state && !mem_ready &&
                         (wait_cnt_q == WCNT_W'(WAIT_LIMIT));

        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        branch_ne   = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        ExtOp       = 1'b1;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_error   = 1'b0;
        state_d     = S_FETCH;

        case (dec_state)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b01;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                mem_error = timeout;
                state_d   = (mem_ready || timeout) ? ((mem_ready) ? S_DECODE : S_FETCH) : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    6'd0:                      state_d = S_R_EXEC;
                    6'd35, 6'd43:              state_d = S_MEM_ADDR;
                    6'd4, 6'd5:                state_d = S_BRANCH;
                    6'd2:                      state_d = S_JUMP;
                    6'd8, 6'd10, 6'd12, 6'd13: state_d = S_I_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == 6'd43) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                mem_error = timeout;
                state_d   = mem_ready ? S_MEM_WB : (timeout ? S_FETCH : S_MEM_READ);
            end
            S_MEM_WB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                // A timed-out store must not commit, so the strobe drops with the error.
                MemWrite   = !timeout;
                IorD       = 1'b1;
                mem_error  = timeout;
                instr_done = mem_ready;
                state_d    = (mem_ready || timeout) ? S_FETCH : S_MEM_WRITE;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                branch_ne   = (opcode == 6'd5);
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                ExtOp   = !((opcode == 6'd12) || (opcode == 6'd13));
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
            mem_error   = 1'b0;
            state_d     = S_FETCH;
        end

        if (rst || timeout || (state_d != dec_state)) begin
            wait_cnt_d = '0;
        end else if (mem_wait_state && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        retired_d = retired_q + (instr_done ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    assign retired = retired_q;
    assign state   = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: an instruction-level model predicts the
// mem_ready timeline, the ending event, its cycle count and the write-back/PC controls.
module tb_multicycle_control;
    localparam int LIMIT = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = 6'd0;
    logic          mem_ready = 1'b0;
    logic          PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp;
    logic [1:0]    ALUSrcB, ALUOp, PCSource;
    logic          instr_done, illegal_op, mem_error;
    logic [CW-1:0] retired;
    logic [3:0]    state;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .branch_ne(branch_ne), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .ExtOp(ExtOp), .instr_done(instr_done),
        .illegal_op(illegal_op), .mem_error(mem_error), .retired(retired), .state(state)
    );

    // kind: 100 = completed, 010 = illegal opcode, 001 = memory timeout
    typedef struct {
        int          len;
        logic [2:0]  kind;
        logic [8:0]  ctrl;   // {RegWrite,RegDst,MemtoReg,MemWrite,PCWrite,PCWriteCond,branch_ne,PCSource}
        bit          prev_chk;
        logic [4:0]  prev;   // {ExtOp,ALUSrcB,ALUOp} in the execute cycle
        logic [31:0] ret;
        logic [5:0]  op;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] model_ret = 0;
    int          cyc = 0;
    bit          after_evt = 1'b0;
    logic [4:0]  prev_v = 5'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Builds the per-cycle stimulus for one instruction from the instruction-level rules.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        bit         mr[$];
        logic [5:0] ops[$];
        exp_t       e;
        e.len = 0; e.kind = 3'b100; e.ctrl = 9'd0; e.prev_chk = 1'b0; e.prev = 5'd0;
        e.ret = model_ret; e.op = op;
        if (wf > LIMIT) begin
            for (int i = 0; i <= LIMIT; i++) begin mr.push_back(1'b0); ops.push_back(6'($urandom)); end
            e.kind = 3'b001;
        end else begin
            for (int i = 0; i < wf; i++) begin mr.push_back(1'b0); ops.push_back(6'($urandom)); end
            mr.push_back(1'b1); ops.push_back(6'($urandom));
            mr.push_back(1'($urandom)); ops.push_back(op);
            case (op)
                6'd0, 6'd8, 6'd10, 6'd12, 6'd13: begin
                    for (int i = 0; i < 2; i++) begin mr.push_back(1'($urandom)); ops.push_back(op); end
                    e.prev_chk = 1'b1;
                    if (op == 6'd0) begin
                        e.ctrl = {1'b1, 1'b1, 7'b0};
                        e.prev = {1'b1, 2'b00, 2'b10};
                    end else begin
                        e.ctrl = {1'b1, 8'b0};
                        e.prev = {((op != 6'd12) && (op != 6'd13)), 2'b10, 2'b11};
                    end
                end
                6'd4, 6'd5: begin
                    mr.push_back(1'($urandom)); ops.push_back(op);
                    e.ctrl = {5'b00000, 1'b1, (op == 6'd5), 2'b01};
                end
                6'd2: begin
                    mr.push_back(1'($urandom)); ops.push_back(op);
                    e.ctrl = {4'b0000, 1'b1, 2'b00, 2'b10};
                end
                6'd35, 6'd43: begin
                    mr.push_back(1'($urandom)); ops.push_back(op);
                    if (wm > LIMIT) begin
                        for (int i = 0; i <= LIMIT; i++) begin mr.push_back(1'b0); ops.push_back(op); end
                        e.kind = 3'b001;
                    end else begin
                        for (int i = 0; i < wm; i++) begin mr.push_back(1'b0); ops.push_back(op); end
                        mr.push_back(1'b1); ops.push_back(op);
                        if (op == 6'd35) begin
                            mr.push_back(1'($urandom)); ops.push_back(op);
                            e.ctrl = {1'b1, 1'b0, 1'b1, 6'b0};
                        end else begin
                            e.ctrl = {3'b000, 1'b1, 5'b0};
                        end
                    end
                end
                default: e.kind = 3'b010;
            endcase
        end
        e.len = mr.size();
        if (e.kind == 3'b100) model_ret++;
        sb.push_back(e);
        for (int i = 0; i < mr.size(); i++) begin
            mem_ready = mr[i];
            opcode    = ops[i];
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops one expectation per end-of-instruction event.
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            after_evt = 1'b0;
        end else begin
            cyc++;
            if (after_evt)
                check("fetch_after_event", {25'd0, MemRead, IorD, ALUSrcA, ALUSrcB, ALUOp}, {25'd0, 7'b1000100});
            after_evt = 1'b0;
            if (instr_done || illegal_op || mem_error) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_event: got %b expected none", {instr_done, illegal_op, mem_error});
                end else begin
                    mon_e = sb.pop_front();
                    $display("txn op=%0d kind=%03b cycles=%0d retired=%0d", mon_e.op,
                             {instr_done, illegal_op, mem_error}, cyc, retired);
                    check("event_kind", {29'd0, instr_done, illegal_op, mem_error}, {29'd0, mon_e.kind});
                    check("cycles", cyc, mon_e.len);
                    check("ctrl", {23'd0, RegWrite, RegDst, MemtoReg, MemWrite, PCWrite, PCWriteCond,
                                   branch_ne, PCSource}, {23'd0, mon_e.ctrl});
                    check("retired", retired, mon_e.ret);
                    if (mon_e.prev_chk) check("exec_selects", {27'd0, prev_v}, {27'd0, mon_e.prev});
                end
                cyc = 0;
                after_evt = 1'b1;
            end else if (cyc > 40) begin
                n_checks++;
                n_err++;
                $display("FAIL watchdog: got %0d idle cycles expected an event within 40", cyc);
                cyc = 0;
            end
            prev_v = {ExtOp, ALUSrcB, ALUOp};
        end
    end

    initial begin
        logic [5:0] op_tab [15];
        int         wf, wm;
        op_tab = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8, 6'd10, 6'd12, 6'd13,
                   6'd1, 6'd3, 6'd6, 6'd40, 6'd63};
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {23'd0, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite,
                              instr_done, illegal_op, mem_error}, 32'd0);
        check("rst_selects", {23'd0, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp}, {23'd0, 9'b0_0_01_00_00_1});
        check("rst_retired", retired, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(6'd0, 0, 0);
        run_instr(6'd35, 0, 3);
        run_instr(6'd12, 1, 0);
        run_instr(6'd8, 0, 0);
        run_instr(6'd5, 0, 0);
        run_instr(6'd4, 2, 0);
        run_instr(6'd63, 0, 0);
        run_instr(6'd43, 0, 50);
        run_instr(6'd43, 0, 4);
        run_instr(6'd35, 4, 0);
        run_instr(6'd2, 9, 0);
        run_instr(6'd13, 0, 0);
        run_instr(6'd10, 0, 0);
        for (int n = 0; n < 150; n++) begin
            wf = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3);
            wm = $urandom_range(0, 6);
            run_instr(op_tab[$urandom_range(0, 14)], wf, wm);
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        check("retired_total", retired, model_ret);

        // Reset in the middle of a stalled store.
        mem_ready = 1'b1;
        opcode = 6'd43;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check("sw_mem_write", {30'd0, MemWrite, IorD}, 32'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_store", {29'd0, MemWrite, RegWrite, instr_done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("fetch_after_rst", {25'd0, MemRead, IorD, ALUSrcA, ALUSrcB, ALUOp}, {25'd0, 7'b1000100});
        check("retired_after_rst", retired, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and write-back over several clocks, driving every datapath select and enable, including ExtOp for the immediate extender (sign vs zero).
- Stalls on a memory ready handshake.
- Sits beside the shared ALU, register file, IR/MDR and unified instruction/data memory.

Parameters:
- WAIT_LIMIT, 0, max cycles spent waiting for mem_ready in one memory state; 0 = wait forever.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26], stable from DECODE until the instruction ends
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if the branch condition holds
- branch_ne  output  1  branch condition is ALU zero==0 (bne); else zero==1
- IorD  output  1  memory address: 0=PC, 1=ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR load
- MemtoReg  output  1  write-back data: 0=ALUOut, 1=MDR
- RegDst  output  1  destination register: 0=rt, 1=rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0=PC, 1=rs
- ALUSrcB  output  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
- ALUOp  output  2  00=add, 01=sub, 10=funct, 11=opcode-decoded immediate op
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
- ExtOp  output  1  1=sign extend, 0=zero extend
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- mem_error  output  1  one-cycle pulse on a memory wait timeout
- retired  output  CNT_W  count of completed instructions
- state  output  4  current state, for debug

Behaviour:
- State register: 4 bits.
  - rst=1 at a clock edge: state<=FETCH, retired<=0, wait counter<=0.
  - While rst=1: all strobes forced 0. These are PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done, illegal_op and mem_error.
  - While rst=1, selects hold their FETCH values. ExtOp=1.
- Outputs are a pure decode of state, plus the opcode and mem_ready terms noted below. Any signal not listed for a state is 0.
- ExtOp=1 in every state except I_EXEC with opcode 12 (andi) or 13 (ori), where it is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 0 -> R_EXEC
  - 35, 43 -> MEM_ADDR
  - 4, 5 -> BRANCH
  - 2 -> JUMP
  - 8, 10, 12, 13 -> I_EXEC
  - any other opcode -> FETCH, with illegal_op=1 and instr_done=0 this cycle; retired unchanged.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ for opcode 35, MEM_WRITE for opcode 43.
- MEM_READ: MemRead=1, IorD=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Waits for mem_ready; then instr_done=1 that cycle and go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Then FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, branch_ne=(opcode==5), instr_done=1.
  - Then FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Then FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Then I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Then FETCH.
- Latencies in clocks, with zero-wait memory:
  - R-type and immediate ops: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j: 3.
- retired increments by 1 on every clock edge where instr_done=1. It wraps modulo 2^CNT_W.
- Wait counter (FETCH, MEM_READ, MEM_WRITE):
  - Clears on entry to each of these states and counts each cycle that mem_ready=0.
  - If WAIT_LIMIT!=0 and the count reaches WAIT_LIMIT with mem_ready still 0, then mem_error=1 and the FSM goes to FETCH.
  - No write strobe fires in that cycle. instr_done=0.
  - mem_ready=1 in the same cycle as the limit is reached wins: normal completion, no error.
- A reset asserted mid-instruction aborts it. No partial write-back; the following cycle is FETCH.
- FSM states never reached from reset decode as FETCH outputs and go to FETCH next cycle.

Test Plan:
- Reset, then opcode=0 with mem_ready=1 held:
  - state sequence FETCH, DECODE, R_EXEC, R_WB, FETCH.
  - RegWrite=1 and RegDst=1 only in R_WB.
  - retired=1 after 4 clocks.
- lw (35) with mem_ready low for 3 cycles in MEM_READ:
  - MemRead=1 and IorD=1 held for 4 cycles, then MEM_WB with MemtoReg=1.
  - Total 8 clocks; retired increments once.
- andi (12) vs addi (8):
  - ExtOp=0 in I_EXEC for andi; ExtOp=1 for addi.
  - ALUSrcB=10 and ALUOp=11 in both.
- bne (5):
  - BRANCH state has PCWriteCond=1, branch_ne=1, PCSource=01, 3-clock instruction.
  - beq (4) gives branch_ne=0.
- Opcode 63 in DECODE:
  - illegal_op pulses 1 cycle, next state FETCH.
  - retired unchanged; no RegWrite or MemWrite.
- WAIT_LIMIT=4, sw (43) with mem_ready=0 forever:
  - mem_error pulses after 4 waiting cycles, MemWrite drops, state returns to FETCH.
- Separately: rst=1 during MEM_WRITE forces MemWrite=0 in that cycle and FETCH on the next.
